ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, RAM word-address width.
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 Parameter LOCK_MAX, default 4, maximum consecutive locked grants to M1.
REQ-004 Port CLK, input, 1, the only clock; all state changes on its rising edge.
REQ-005 Port RESET, input, 1, synchronous, active-high reset.
REQ-006 Ports REQ_M0/REQ_M1, input, 1 each, access request from M0 (CPU) and M1 (DMA/loader).
REQ-007 Ports WE_M0/WE_M1, input, 1 each, 1 = write, 0 = read.
REQ-008 Ports ADDR_M0/ADDR_M1, input, ADDR_W each, word address.
REQ-009 Ports WDATA_M0/WDATA_M1, input, DATA_W each, write data.
REQ-010 Port LOCK_M1, input, 1, M1 requests consecutive grants (atomic read-modify-write).
REQ-011 Ports GNT_M0/GNT_M1, output, 1 each, access-performed pulse.
REQ-012 Port RDATA, output, DATA_W, read data, valid in the GNT cycle of a read.
REQ-013 Ports RAM_ADDR (ADDR_W), RAM_WRITE_DATA (DATA_W), RAM_WRITE_ENABLE (1), output, drive the single-port RAM.
REQ-014 Port RAM_READ_DATA, input, DATA_W, combinational RAM read of RAM_ADDR.

Function
REQ-015 FSM states IDLE, SERVE_M0 and SERVE_M1; arbitration happens on every rising edge, from any state.
REQ-016 Arbitration at an edge: no REQ -> IDLE; one REQ -> SERVE that master; both REQ -> lock rule (REQ-019) first, else round-robin.
REQ-017 On the edge entering SERVE_Mx, WE/ADDR/WDATA of Mx are latched into a command register; the grant latency is therefore 1 cycle from REQ sampling.
REQ-018 Round-robin: a last-served pointer (reset = M1) makes the master not served last win a tie, so two continuous requesters alternate M0, M1, M0...
REQ-019 Lock: if the previous state was SERVE_M1 with LOCK_M1 latched high, REQ_M1 is high and lock_cnt < LOCK_MAX, then M1 wins regardless of pointer.
REQ-020 lock_cnt increments on each locked re-grant and clears on any M0 grant or on IDLE.
REQ-021 In SERVE_Mx: GNT_Mx = 1, other GNT = 0, RAM_ADDR = latched address, RAM_WRITE_DATA = latched data, RAM_WRITE_ENABLE = latched WE AND NOT RESET.
REQ-022 In SERVE_Mx for a read, RDATA = RAM_READ_DATA; otherwise RDATA = 0.
REQ-023 In IDLE: all GNT = 0, RAM_WRITE_ENABLE = 0, RAM_ADDR = 0, RAM_WRITE_DATA = 0.
REQ-024 A REQ still high during its own GNT cycle is a new request carrying the command present in that cycle; a single master can thus sustain 1 access per cycle.
REQ-025 A requester holds REQ and its command stable until its GNT cycle; a REQ dropped before the sampling edge is never served.
REQ-026 A write commits at the edge ending its GNT cycle; a read in the same cycle as a write is impossible by construction.

Reset
REQ-027 While RESET is high: RAM_WRITE_ENABLE = 0 combinationally, so a write in flight is aborted.
REQ-028 At the first edge with RESET high: state = IDLE, pointer = M1, lock_cnt = 0, command register = 0.
REQ-029 Requests present during RESET are ignored; arbitration resumes at the first edge with RESET low.

Structure
REQ-030 Package ram_arb_pkg holds the state enum, default ADDR_W/DATA_W/LOCK_MAX and the master-index constants M0 = 0, M1 = 1.
REQ-031 One sub-module, ram_arb_rr (2-way round-robin picker with lock override), is natural; everything else stays in ram_arbiter.

Verification
REQ-032 M0 write 0xDEADBEEF to 5, then read 5 -> GNT_M0 in cycles 1 and 2, RDATA = 0xDEADBEEF in cycle 2.
REQ-033 Both REQ continuously, after reset -> grant order M0, M1, M0, M1, one grant per cycle.
REQ-034 M1 with LOCK_M1 = 1 and M0 requesting throughout -> M1 served 5 consecutive cycles (1 + LOCK_MAX), then M0.
REQ-035 RESET raised during SERVE_M1 write of 0x12345678 to 7 -> RAM_WRITE_ENABLE = 0, address 7 unchanged, state IDLE after the edge.
REQ-036 M1 read of 3 in the same cycle as M0 write of 0xA5A5A5A5 to 3, pointer = M1 -> M0 write first, M1 read returns 0xA5A5A5A5.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the RAM arbiter
package ram_arb_pkg;

    localparam int ADDR_W_DEF   = 10;
    localparam int DATA_W_DEF   = 32;
    localparam int LOCK_MAX_DEF = 4;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_M0,
        SERVE_M1
    } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - request/grant and RAM bus bundle for the RAM arbiter
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              REQ_M0;
    logic              REQ_M1;
    logic              WE_M0;
    logic              WE_M1;
    logic [ADDR_W-1:0] ADDR_M0;
    logic [ADDR_W-1:0] ADDR_M1;
    logic [DATA_W-1:0] WDATA_M0;
    logic [DATA_W-1:0] WDATA_M1;
    logic              LOCK_M1;
    logic              GNT_M0;
    logic              GNT_M1;
    logic [DATA_W-1:0] RDATA;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic [DATA_W-1:0] RAM_WRITE_DATA;
    logic              RAM_WRITE_ENABLE;
    logic [DATA_W-1:0] RAM_READ_DATA;

    // The arbiter side
    modport slave (
        input  REQ_M0, REQ_M1, WE_M0, WE_M1, ADDR_M0, ADDR_M1,
        input  WDATA_M0, WDATA_M1, LOCK_M1, RAM_READ_DATA,
        output GNT_M0, GNT_M1, RDATA, RAM_ADDR, RAM_WRITE_DATA, RAM_WRITE_ENABLE
    );

    // The requesters plus RAM side
    modport master (
        output REQ_M0, REQ_M1, WE_M0, WE_M1, ADDR_M0, ADDR_M1,
        output WDATA_M0, WDATA_M1, LOCK_M1, RAM_READ_DATA,
        input  GNT_M0, GNT_M1, RDATA, RAM_ADDR, RAM_WRITE_DATA, RAM_WRITE_ENABLE
    );

endinterface

// File: rtl/ram_arb_rr.sv
// rtl/ram_arb_rr.sv - two-way round-robin picker with an M1 lock override
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic lock_hold,
    output logic valid,
    output logic pick
);

    always_comb begin
        valid = req0 | req1;
        pick  = M0;
        if (req0 && req1) begin
            // A held lock beats fairness; otherwise whoever was not served last wins
            pick = lock_hold ? M1 : ~last;
        end else if (req1) begin
            pick = M1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter for a CPU (M0) and a DMA/loader (M1)
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic           CLK,
    input  logic           RESET,
    ram_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    state_t            state_q;
    state_t            state_d;
    logic              last_q;
    logic [CNT_W-1:0]  lock_cnt_q;
    logic              lock_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              lock_hold;
    logic              pick_valid;
    logic              pick;

    assign lock_hold = (state_q == SERVE_M1) && lock_q && bus.REQ_M1
                       && (lock_cnt_q < CNT_W'(LOCK_MAX));

    ram_arb_rr u_rr (
        .req0      (bus.REQ_M0),
        .req1      (bus.REQ_M1),
        .last      (last_q),
        .lock_hold (lock_hold),
        .valid     (pick_valid),
        .pick      (pick)
    );

    always_comb begin
        state_d = IDLE;
        if (pick_valid) begin
            state_d = (pick == M1) ? SERVE_M1 : SERVE_M0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            last_q     <= M1;
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_d)
                SERVE_M0: begin
                    last_q     <= M0;
                    lock_cnt_q <= '0;
                    lock_q     <= 1'b0;
                    we_q       <= bus.WE_M0;
                    addr_q     <= bus.ADDR_M0;
                    wdata_q    <= bus.WDATA_M0;
                end
                SERVE_M1: begin
                    last_q  <= M1;
                    lock_q  <= bus.LOCK_M1;
                    we_q    <= bus.WE_M1;
                    addr_q  <= bus.ADDR_M1;
                    wdata_q <= bus.WDATA_M1;
                    if (lock_hold) begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end
                default: begin
                    lock_cnt_q <= '0;
                    lock_q     <= 1'b0;
                end
            endcase
        end
    end

    // Write enable is gated by RESET combinationally so an in-flight write aborts
    always_comb begin
        bus.GNT_M0           = 1'b0;
        bus.GNT_M1           = 1'b0;
        bus.RDATA            = '0;
        bus.RAM_ADDR         = '0;
        bus.RAM_WRITE_DATA   = '0;
        bus.RAM_WRITE_ENABLE = 1'b0;
        if (state_q != IDLE) begin
            bus.GNT_M0           = (state_q == SERVE_M0);
            bus.GNT_M1           = (state_q == SERVE_M1);
            bus.RAM_ADDR         = addr_q;
            bus.RAM_WRITE_DATA   = wdata_q;
            bus.RAM_WRITE_ENABLE = we_q & ~RESET;
            if (!we_q) begin
                bus.RDATA = bus.RAM_READ_DATA;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    int   total  = 0;
    int   passed = 0;

    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (bus.RAM_WRITE_ENABLE) begin
            mem[bus.RAM_ADDR] <= bus.RAM_WRITE_DATA;
        end
    end

    assign bus.RAM_READ_DATA = mem[bus.RAM_ADDR];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_gnt(input string tag, input logic e0, input logic e1);
        chk(tag, 32'({bus.GNT_M0, bus.GNT_M1}), 32'({e0, e1}));
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
        bus.REQ_M0   = req;
        bus.WE_M0    = we;
        bus.ADDR_M0  = addr;
        bus.WDATA_M0 = data;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic lock);
        bus.REQ_M1   = req;
        bus.WE_M1    = we;
        bus.ADDR_M1  = addr;
        bus.WDATA_M1 = data;
        bus.LOCK_M1  = lock;
    endtask

    initial begin
        set_m0(1'b0, 1'b0, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0, 1'b0);

        // Reset state
        tick();
        tick();
        chk_gnt("reset_gnt", 1'b0, 1'b0);
        chk("reset_we", 32'(bus.RAM_WRITE_ENABLE), 32'd0);
        chk("reset_addr", 32'(bus.RAM_ADDR), 32'd0);
        RESET = 1'b0;

        // M0 write then read of address 5, back to back
        set_m0(1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
        tick();
        chk_gnt("wr5_gnt", 1'b1, 1'b0);
        chk("wr5_we", 32'(bus.RAM_WRITE_ENABLE), 32'd1);
        chk("wr5_addr", 32'(bus.RAM_ADDR), 32'd5);
        chk("wr5_data", bus.RAM_WRITE_DATA, 32'hDEADBEEF);
        chk("wr5_rdata", bus.RDATA, 32'd0);
        set_m0(1'b1, 1'b0, 10'd5, '0);
        tick();
        chk_gnt("rd5_gnt", 1'b1, 1'b0);
        chk("rd5_we", 32'(bus.RAM_WRITE_ENABLE), 32'd0);
        chk("rd5_rdata", bus.RDATA, 32'hDEADBEEF);
        set_m0(1'b0, 1'b0, '0, '0);
        tick();
        chk_gnt("idle_gnt", 1'b0, 1'b0);
        chk("idle_rdata", bus.RDATA, 32'd0);
        chk("idle_addr", 32'(bus.RAM_ADDR), 32'd0);

        // Requests during reset are ignored; then both alternate starting with M0
        set_m0(1'b1, 1'b0, 10'd5, '0);
        set_m1(1'b1, 1'b0, 10'd6, '0, 1'b0);
        RESET = 1'b1;
        tick();
        chk_gnt("rst_ignore_gnt", 1'b0, 1'b0);
        RESET = 1'b0;
        tick();
        chk_gnt("rr0_gnt", 1'b1, 1'b0);
        chk("rr0_addr", 32'(bus.RAM_ADDR), 32'd5);
        tick();
        chk_gnt("rr1_gnt", 1'b0, 1'b1);
        chk("rr1_addr", 32'(bus.RAM_ADDR), 32'd6);
        tick();
        chk_gnt("rr2_gnt", 1'b1, 1'b0);
        tick();
        chk_gnt("rr3_gnt", 1'b0, 1'b1);
        set_m0(1'b0, 1'b0, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        chk_gnt("rr_idle_gnt", 1'b0, 1'b0);

        // Lock: M1 gets 1 + LOCK_MAX consecutive grants against a waiting M0
        set_m0(1'b1, 1'b0, 10'd5, '0);
        tick();
        chk_gnt("lk_pre_gnt", 1'b1, 1'b0);
        set_m1(1'b1, 1'b0, 10'd5, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_gnt($sformatf("lk_m1_%0d", i), 1'b0, 1'b1);
        end
        tick();
        chk_gnt("lk_m0_after", 1'b1, 1'b0);
        set_m0(1'b0, 1'b0, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        chk_gnt("lk_idle_gnt", 1'b0, 1'b0);

        // Aborted write: reset lands during an M1 write to 7
        set_m0(1'b1, 1'b1, 10'd7, 32'h0BADF00D);
        tick();
        chk_gnt("pre7_gnt", 1'b1, 1'b0);
        set_m0(1'b0, 1'b0, '0, '0);
        tick();
        set_m1(1'b1, 1'b1, 10'd7, 32'h12345678, 1'b0);
        tick();
        chk_gnt("ab_gnt", 1'b0, 1'b1);
        chk("ab_we_before", 32'(bus.RAM_WRITE_ENABLE), 32'd1);
        RESET = 1'b1;
        #1;
        chk("ab_we_rst", 32'(bus.RAM_WRITE_ENABLE), 32'd0);
        chk("ab_addr_rst", 32'(bus.RAM_ADDR), 32'd7);
        tick();
        chk_gnt("ab_after_gnt", 1'b0, 1'b0);
        chk("ab_after_addr", 32'(bus.RAM_ADDR), 32'd0);
        set_m1(1'b0, 1'b0, '0, '0, 1'b0);
        RESET = 1'b0;
        tick();

        // Same-cycle M0 write and M1 read of 3 with pointer at M1
        set_m0(1'b1, 1'b1, 10'd3, 32'hA5A5A5A5);
        set_m1(1'b1, 1'b0, 10'd3, '0, 1'b0);
        tick();
        chk_gnt("wr3_gnt", 1'b1, 1'b0);
        chk("wr3_we", 32'(bus.RAM_WRITE_ENABLE), 32'd1);
        chk("wr3_addr", 32'(bus.RAM_ADDR), 32'd3);
        set_m0(1'b0, 1'b0, '0, '0);
        tick();
        chk_gnt("rd3_gnt", 1'b0, 1'b1);
        chk("rd3_rdata", bus.RDATA, 32'hA5A5A5A5);
        set_m1(1'b0, 1'b0, '0, '0, 1'b0);

        // Address 7 must still hold the value from before the aborted write
        set_m0(1'b1, 1'b0, 10'd7, '0);
        tick();
        chk_gnt("rd7_gnt", 1'b1, 1'b0);
        chk("rd7_rdata", bus.RDATA, 32'h0BADF00D);
        set_m0(1'b0, 1'b0, '0, '0);
        tick();
        chk_gnt("end_idle_gnt", 1'b0, 1'b0);
        chk("end_idle_rdata", bus.RDATA, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
